// File: rtl/dsp_result_drain.sv
// Result drain: queues full-width DSP result words in a small FIFO and
// streams each one out as NBEATS narrow beats, least-significant beat first.
module dsp_result_drain #(
  parameter int WIDTH  = 48,
  parameter int BEAT_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CE,
  input  logic [WIDTH-1:0]         P_IN,
  input  logic                     P_VALID,
  output logic                     P_READY,
  output logic [BEAT_W-1:0]        D_OUT,
  output logic                     D_VALID,
  output logic                     D_LAST,
  input  logic                     D_READY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int NBEATS = WIDTH / BEAT_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic [BW-1:0]       r_beat;

  logic                w_push;
  logic                w_xfer;
  logic                w_final;
  logic                w_pop;
  logic [WIDTH-1:0]    w_head;
  logic [BEAT_W-1:0]   w_beats [NBEATS];

  // Readiness is judged on the current occupancy, so a full FIFO refuses a
  // push even when the head word leaves on the same edge.
  assign P_READY = CE && (r_count < CW'(DEPTH));
  assign D_VALID = CE && (r_state == S_SEND);
  assign w_final = (r_beat == BW'(NBEATS - 1));
  assign D_LAST  = D_VALID && w_final;
  assign COUNT   = r_count;

  assign w_push  = P_VALID && P_READY;
  assign w_xfer  = D_VALID && D_READY;
  assign w_pop   = w_xfer && w_final;

  assign w_head  = r_mem[r_rptr];

  for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
    assign w_beats[gi] = w_head[gi*BEAT_W +: BEAT_W];
  end

  always_comb begin
    D_OUT = '0;
    if (r_state == S_SEND) begin
      for (int i = 0; i < NBEATS; i++) begin
        if (r_beat == BW'(i)) D_OUT = w_beats[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_push) w_state_next = S_SEND;
      S_SEND: if (w_pop && !w_push && (r_count == CW'(1))) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Storage is deliberately left out of reset; stale words are never shown.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= P_IN;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_xfer) r_beat <= w_final ? '0 : r_beat + BW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_result_drain.sv
// Bench for dsp_result_drain: directed scenarios followed by random traffic,
// all checked against a queue-of-beats reference model.
module tb_dsp_result_drain;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic [47:0] P_IN;
  logic        P_VALID;
  logic        P_READY;
  logic [15:0] D_OUT;
  logic        D_VALID;
  logic        D_LAST;
  logic        D_READY;
  logic [2:0]  COUNT;

  always #5 CLK = ~CLK;

  dsp_result_drain #(.WIDTH(48), .BEAT_W(16), .DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .P_IN(P_IN), .P_VALID(P_VALID),
    .P_READY(P_READY), .D_OUT(D_OUT), .D_VALID(D_VALID), .D_LAST(D_LAST),
    .D_READY(D_READY), .COUNT(COUNT)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Every beat still owed to the sink, in delivery order: {last, data}.
  logic [16:0] beat_q[$];
  bit          after_rst = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_push(input logic [47:0] w);
    for (int k = 0; k < 3; k++) beat_q.push_back({(k == 2), w[k*16 +: 16]});
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, then
  // advance the model by whatever the rising edge will transfer.
  task automatic step(input logic ce, input logic pv, input logic [47:0] pin,
                      input logic dr, input logic rn);
    int words;
    bit exp_pr;
    bit exp_dv;
    logic [16:0] head;
    CE = ce; P_VALID = pv; P_IN = pin; D_READY = dr; RST_N = rn;
    #1;
    words  = (beat_q.size() + 2) / 3;
    exp_pr = ce && (words < 4);
    exp_dv = ce && (beat_q.size() > 0);
    head   = (beat_q.size() > 0) ? beat_q[0] : 17'h0;
    check("count", COUNT, words);
    check("p_ready", P_READY, exp_pr);
    check("d_valid", D_VALID, exp_dv);
    if (exp_dv) begin
      check("d_out", D_OUT, head[15:0]);
      check("d_last", D_LAST, head[16]);
    end else begin
      check("d_last_idle", D_LAST, 1'b0);
    end
    if (after_rst) check("d_out_rst", D_OUT, 16'h0);
    after_rst = 1'b0;
    if (!rn) begin
      beat_q.delete();
      after_rst = 1'b1;
    end else begin
      if (exp_dv && dr) void'(beat_q.pop_front());
      if (pv && exp_pr) model_push(pin);
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
  endtask

  initial begin
    RST_N = 1'b0; CE = 1'b1; P_IN = '0; P_VALID = 1'b0; D_READY = 1'b0;
    @(negedge CLK);
    step(1'b1, 1'b0, 48'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 48'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 48'h0, 1'b0, 1'b1);

    // Single word: three beats, LSB first, last flagged on the third.
    step(1'b1, 1'b1, 48'h0123_4567_89AB, 1'b1, 1'b1);
    check("single_b0", D_OUT, 16'h89AB);
    idle(4);

    // Fill to full with the sink stalled, then drain.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    check("full_count", COUNT, 3'd4);
    check("full_ready", P_READY, 1'b0);
    idle(13);

    // Backpressure during one word.
    step(1'b1, 1'b1, 48'hAAAA_5555_1234, 1'b0, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
    idle(2);

    // Full with a final-beat pop and a push on the same edge.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 48'h1111_2222_3333, 1'b1, 1'b1);
    check("full_pop_count", COUNT, 3'd3);
    step(1'b1, 1'b1, 48'h4444_5555_6666, 1'b0, 1'b1);
    idle(14);

    // Clock-enable stall mid-word.
    step(1'b1, 1'b1, 48'h0A0A_0B0B_0C0C, 1'b0, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 48'hDEAD_BEEF_0000, 1'b1, 1'b1);
    idle(3);

    // Reset mid-word with words queued, then a fresh word.
    step(1'b1, 1'b1, 48'h1234_5678_9ABC, 1'b0, 1'b1);
    step(1'b1, 1'b1, 48'h0FED_CBA9_8765, 1'b1, 1'b1);
    step(1'b1, 1'b0, 48'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 48'h7777_8888_9999, 1'b0, 1'b0);
    step(1'b1, 1'b1, 48'hFFFF_0000_AAAA, 1'b1, 1'b1);
    check("post_rst_b0", D_OUT, 16'hAAAA);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), $urandom_range(0, 1), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
    end
    idle(16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
